// File: rtl/osfm_pkg.sv
// Shared types and default parameter values for the operand-shifted fixed-point multiplier.
package osfm_pkg;

    // Per-transaction multiply mode
    typedef enum logic {
        OSFM_EXACT  = 1'b0,
        OSFM_APPROX = 1'b1
    } osfm_mode_e;

    localparam int OSFM_WIDTH  = 16;
    localparam int OSFM_IWIDTH = 8;
    localparam int OSFM_FRAC   = 8;
    localparam int OSFM_STEP   = 2;
    localparam int OSFM_CNTW   = 16;
    localparam int OSFM_STAGES = 3;

endpackage

// File: rtl/osfm_operand_shifter.sv
// Picks the smallest STEP-aligned right shift that makes an operand fit the
// inner multiplier, and returns the kept IWIDTH-bit window plus the shift.
module osfm_operand_shifter #(
    parameter int WIDTH  = 16,
    parameter int IWIDTH = 8,
    parameter int STEP   = 2,
    parameter int SW     = 4
) (
    input  logic [WIDTH-1:0]  x,
    output logic [IWIDTH-1:0] xs,
    output logic [SW-1:0]     s
);

    localparam int NSTEP = (WIDTH - IWIDTH) / STEP;

    // Scan from the largest shift down so the last hit is the smallest fitting shift
    always_comb begin
        s = SW'(WIDTH - IWIDTH);
        for (int k = NSTEP; k >= 0; k--) begin
            if (((x >> (k * STEP)) >> IWIDTH) == '0)
                s = SW'(k * STEP);
        end
        xs = IWIDTH'(x >> s);
    end

endmodule

// File: rtl/osfm_pipe.sv
// Three-stage unsigned fixed-point multiplier with an exact full-width path and
// an approximate operand-shifted IWIDTH x IWIDTH path, selected per transaction.
module osfm_pipe
    import osfm_pkg::*;
#(
    parameter int WIDTH  = OSFM_WIDTH,
    parameter int IWIDTH = OSFM_IWIDTH,
    parameter int FRAC   = OSFM_FRAC,
    parameter int STEP   = OSFM_STEP,
    parameter int CNTW   = OSFM_CNTW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_sat,
    input  logic             cnt_clr,
    output logic [CNTW-1:0]  approx_cnt
);

    localparam int PW     = 2 * WIDTH;
    localparam int SW     = $clog2(WIDTH - IWIDTH + 1);
    localparam int STAGES = OSFM_STAGES;

    logic                advance;
    logic                accept;
    logic [STAGES:1]     vld_pipe;

    logic [IWIDTH-1:0]   ax_in, bx_in;
    logic [SW-1:0]       sa_in, sb_in;
    logic                approx_hit;

    logic [WIDTH-1:0]    s1_a, s1_b;
    logic [IWIDTH-1:0]   s1_ax, s1_bx;
    logic [SW-1:0]       s1_sa, s1_sb;
    osfm_mode_e          s1_mode;

    logic [2*IWIDTH-1:0] core_p;
    logic [SW:0]         sh_sum;
    logic [PW-1:0]       approx_p, exact_p;
    logic [PW-1:0]       s2_p;
    logic                s2_ovf;

    // Global stall: everything moves only when the output slot can drain
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[STAGES];

    osfm_operand_shifter #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .STEP(STEP), .SW(SW)) u_shift_a (
        .x  (in_a),
        .xs (ax_in),
        .s  (sa_in)
    );

    osfm_operand_shifter #(.WIDTH(WIDTH), .IWIDTH(IWIDTH), .STEP(STEP), .SW(SW)) u_shift_b (
        .x  (in_b),
        .xs (bx_in),
        .s  (sb_in)
    );

    assign approx_hit = accept && (in_mode == OSFM_APPROX) && (sa_in != '0 || sb_in != '0);

    // Valid shift register; bubbles travel with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // S1: capture raw operands for the exact path and shifted windows for the approximate path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a    <= '0;
            s1_b    <= '0;
            s1_ax   <= '0;
            s1_bx   <= '0;
            s1_sa   <= '0;
            s1_sb   <= '0;
            s1_mode <= OSFM_EXACT;
        end else if (accept) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_ax   <= ax_in;
            s1_bx   <= bx_in;
            s1_sa   <= sa_in;
            s1_sb   <= sb_in;
            s1_mode <= osfm_mode_e'(in_mode);
        end
    end

    // Narrow core plus re-alignment, and the separate full-width product
    assign core_p   = (2*IWIDTH)'(s1_ax) * (2*IWIDTH)'(s1_bx);
    assign sh_sum   = {1'b0, s1_sa} + {1'b0, s1_sb};
    assign approx_p = PW'(core_p) << sh_sum;
    assign exact_p  = PW'(s1_a) * PW'(s1_b);

    // S2: register the product chosen by the registered mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_p <= '0;
        else if (advance && vld_pipe[1])
            s2_p <= (s1_mode == OSFM_APPROX) ? approx_p : exact_p;
    end

    // Anything at or above 2^(FRAC+WIDTH) cannot be represented after dropping FRAC bits
    assign s2_ovf = |(s2_p >> (FRAC + WIDTH));

    // S3: truncate or saturate; held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r   <= '0;
            out_sat <= 1'b0;
        end else if (advance && vld_pipe[2]) begin
            out_r   <= s2_ovf ? '1 : s2_p[FRAC+WIDTH-1:FRAC];
            out_sat <= s2_ovf;
        end
    end

    // Count accepted transactions that actually lost low operand bits; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            approx_cnt <= '0;
        else if (cnt_clr)
            approx_cnt <= '0;
        else if (approx_hit && approx_cnt != '1)
            approx_cnt <= approx_cnt + 1'b1;
    end

endmodule

// File: tb/tb_osfm_pipe.sv
// Scoreboard bench for osfm_pipe: stimulus pushes model results, a negedge monitor pops and compares.
module tb_osfm_pipe;

    localparam int W  = 16;
    localparam int IW = 8;
    localparam int FR = 8;
    localparam int ST = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_mode;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready, out_sat;
    logic [W-1:0]  out_r;
    logic          cnt_clr;
    logic [CW-1:0] approx_cnt;

    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [W:0]    exp_q[$];
    int            mcnt = 0;
    bit            rand_ready = 1'b0;
    bit            held = 1'b0;
    logic [W:0]    held_val;

    osfm_pipe #(.WIDTH(W), .IWIDTH(IW), .FRAC(FR), .STEP(ST), .CNTW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_sat    (out_sat),
        .cnt_clr    (cnt_clr),
        .approx_cnt (approx_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Smallest STEP multiple s with x < 2^(s+IW), capped at W-IW
    function automatic int shamt(input longint unsigned x);
        int s = 0;
        while (s < W - IW && x >= (64'd1 << (s + IW))) s += ST;
        return s;
    endfunction

    function automatic void model(input longint unsigned a, input longint unsigned b, input bit m,
                                  output logic [W:0] res, output bit lossy);
        longint unsigned p;
        int sa, sb;
        lossy = 1'b0;
        if (m) begin
            sa = shamt(a);
            sb = shamt(b);
            p = ((a >> sa) * (b >> sb)) << (sa + sb);
            lossy = (sa > 0) || (sb > 0);
        end else begin
            p = a * b;
        end
        if (p >= (64'd1 << (FR + W))) res = {1'b1, {W{1'b1}}};
        else                          res = {1'b0, W'(p >> FR)};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit m, input bit clr = 1'b0);
        logic [W:0] res;
        bit lossy, rdy, ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1; cnt_clr = clr;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk);
            if (rdy) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        else begin
            model(a, b, m, res, lossy);
            exp_q.push_back(res);
            if (clr) mcnt = 0;
            else if (lossy && mcnt < (1 << CW) - 1) mcnt++;
        end
        #1;
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        v = W'($urandom_range(0, 16'hFFFF));
        return v >> $urandom_range(0, 15);
    endfunction

    // Random consumer back-pressure, changed just after each rising edge
    always begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pop on every output transfer, and require held outputs to be stable
    always @(negedge clk) begin
        if (rst) held = 1'b0;
        else begin
            if (held && out_valid) chk("stall_stable", {out_sat, out_r}, held_val);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_output", {out_sat, out_r}, 0 ^ {1'b1, {W{1'b0}}} ^ {out_sat, out_r} ^ {1'b1, {W{1'b0}}} ^ 1);
                else chk("result", {out_sat, out_r}, exp_q.pop_front());
            end
            held = out_valid && !out_ready;
            held_val = {out_sat, out_r};
        end
    end

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_approx_cnt", approx_cnt, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Small a, b needing a shift; latency counted including the accepting edge
        send(16'h0003, 16'h0100, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, 3);
        chk("cnt_shift_b", approx_cnt, mcnt);
        drain();

        send(16'h0155, 16'h0100, 1'b1);
        send(16'h0155, 16'h0100, 1'b0);
        chk("cnt_after_mixed", approx_cnt, mcnt);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        chk("cnt_exact_sat", approx_cnt, mcnt);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        chk("cnt_approx_sat", approx_cnt, mcnt);
        drain();

        // Eight back-to-back mixed-mode inputs with the consumer stalled on cycles 4..6
        fork
            begin
                for (int i = 0; i < 8; i++) send(rnd_op() | 16'h0100, rnd_op(), i[0]);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 4 && c <= 6);
                    @(negedge clk);
                    if (c >= 4 && c <= 6) chk("stall_in_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Randomized traffic with random back-pressure and input gaps
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("cnt_random", approx_cnt, mcnt);
        chk("cnt_nonzero", (approx_cnt != 0), 1);

        // Clear coincident with a counted approximate accept
        send(16'h0155, 16'h0100, 1'b1, 1'b1);
        chk("cnt_clr_wins", approx_cnt, mcnt);
        drain();

        // Reset with three transactions in flight
        send(16'h0155, 16'h0100, 1'b1);
        send(16'h1234, 16'h0456, 1'b1);
        send(16'h0FFF, 16'h0021, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_r", out_r, 0);
        chk("midrst_out_sat", out_sat, 0);
        chk("midrst_approx_cnt", approx_cnt, 0);
        exp_q.delete();
        mcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_output", out_valid, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
